// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS datapath and mc_controller.
// The master modport is the controller side; slave is the datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       mem_ready;
  logic       zero;
  logic       rs_neg;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic [2:0] state;
  logic       illegal;

  modport master (
    input  op, funct, rt, mem_ready, zero, rs_neg,
    output pc_write, ir_write, mem_read, mem_write, iord, reg_write,
           reg_dst, mem_to_reg, alu_src_b, pc_source, alu_src_a, alu_op,
           state, illegal
  );

  modport slave (
    output op, funct, rt, mem_ready, zero, rs_neg,
    input  pc_write, ir_write, mem_read, mem_write, iord, reg_write,
           reg_dst, mem_to_reg, alu_src_b, pc_source, alu_src_a, alu_op,
           state, illegal
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM: fetch, decode, execute, memory, writeback.
// Define MC_CONTROLLER_BGEZ_EN to decode bgez/bgezal; otherwise op 0x01 is illegal.
module mc_controller (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SRLV, I_JR, I_ORI, I_LUI, I_LW, I_SW,
    I_BEQ, I_JAL, I_BGEZ, I_BGEZAL, I_ILL
  } instr_t;

  state_t     state_q, state_d;
  instr_t     instr;
  logic       is_rtype_alu;

  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, illegal;
  logic [2:0] alu_op;

  always_comb begin
    instr = I_ILL;
    case (bus.op)
      6'h00: begin
        case (bus.funct)
          6'h21:   instr = I_ADDU;
          6'h23:   instr = I_SUBU;
          6'h06:   instr = I_SRLV;
          6'h08:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      6'h0D: instr = I_ORI;
      6'h0F: instr = I_LUI;
      6'h23: instr = I_LW;
      6'h2B: instr = I_SW;
      6'h04: instr = I_BEQ;
      6'h03: instr = I_JAL;
`ifdef MC_CONTROLLER_BGEZ_EN
      6'h01: begin
        if (bus.rt == 5'b00001)      instr = I_BGEZ;
        else if (bus.rt == 5'b10001) instr = I_BGEZAL;
      end
`endif
      default: instr = I_ILL;
    endcase
  end

  assign is_rtype_alu = (instr == I_ADDU) || (instr == I_SUBU) || (instr == I_SRLV);

`ifndef MC_CONTROLLER_BGEZ_EN
  logic [5:0] unused_bgez_inputs;
  assign unused_bgez_inputs = {bus.rt, bus.rs_neg};
`endif

  // Codes 5-7 fall into the default arm: all outputs idle, back to fetch.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_op     = 3'b000;
    illegal    = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DCD;
      end

      S_DCD: begin
        alu_src_b = 2'b11;
        state_d   = S_EXE;
        case (instr)
          I_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            state_d    = S_IF;
          end
          I_JR: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
            state_d   = S_IF;
          end
          I_ILL: begin
            illegal = 1'b1;
            state_d = S_IF;
          end
          default: ;
        endcase
      end

      S_EXE: begin
        alu_src_a = 1'b1;
        state_d   = S_WB;
        case (instr)
          I_SUBU: alu_op = 3'b001;
          I_SRLV: alu_op = 3'b100;
          I_ORI: begin
            alu_src_b = 2'b10;
            alu_op    = 3'b011;
          end
          I_LW, I_SW: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          I_BEQ: begin
            alu_op    = 3'b001;
            pc_source = 2'b01;
            pc_write  = bus.zero;
            state_d   = S_IF;
          end
`ifdef MC_CONTROLLER_BGEZ_EN
          I_BGEZ: begin
            pc_source = 2'b01;
            pc_write  = !bus.rs_neg;
            state_d   = S_IF;
          end
          // Link is written unconditionally so it captures PC+4 before any redirect.
          I_BGEZAL: begin
            pc_source  = 2'b01;
            pc_write   = !bus.rs_neg;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            state_d    = S_IF;
          end
`endif
          I_JAL, I_JR, I_ILL: state_d = S_IF;
          default: ;
        endcase
      end

      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (instr == I_LW);
        mem_write = (instr == I_SW);
        if (bus.mem_ready) state_d = (instr == I_LW) ? S_WB : S_IF;
      end

      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_IF;
        if (is_rtype_alu)        reg_dst    = 2'b01;
        else if (instr == I_LUI) mem_to_reg = 2'b11;
        else if (instr == I_LW)  mem_to_reg = 2'b01;
      end

      default: state_d = S_IF;
    endcase

    // A reset cycle must never commit architectural state.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.iord       = iord;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_source  = pc_source;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_op     = alu_op;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal;

endmodule
